mul_issue_ctrl: RTL

//  Sequences the shared 64x64 Wallace-tree multiplier (combinational, 128-bit product) between
//  two VLIW issue lanes. Arbitrates lane requests, registers operands, handles signed operands
//  by sign-magnitude conversion, waits a fixed multicycle settle time and returns the product
//  to the winning lane through a valid/ready response channel. Sits between decode/issue and writeback.

---
 rtl/mul_issue_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mul_issue_ctrl
//   Shares one 64x64 combinational multiplier (128-bit unsigned product)
//   between two VLIW issue lanes. In IDLE it grants at most one lane, using a
//   round-robin pointer to pick a lane when both are valid. On the accepting
//   edge it latches the lane, the tag, the result sign, and the operand
//   magnitudes. It then holds the operands on mul_a/mul_b for LAT cycles.
//   Next it captures the product, re-signed if needed. Finally it presents
//   the result on a valid/ready response channel until writeback takes it.
//
// Parameters
//   LAT    multiplier settle cycles (>= 1)
//   TAG_W  destination tag width
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req_valid[1:0]        per-lane multiply request
//   req_ready[1:0]        per-lane accept (one-hot or zero, only in IDLE)
//   req_sgn[1:0]          per-lane operands are two's-complement signed
//   req_a0/req_b0         lane 0 operands
//   req_a1/req_b1         lane 1 operands
//   req_tag0/req_tag1     lane 0/1 destination tags
//   mul_a/mul_b           operand magnitudes driven to the multiplier
//   mul_p                 unsigned product returned by the multiplier
//   rsp_valid/rsp_ready   response handshake
//   rsp_lane/rsp_tag      origin lane and tag of the returned op
//   rsp_prod              final 128-bit product
//   busy                  controller is not idle
// ---------------------------------------------------------------------------
module mul_issue_ctrl #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_sgn,
  input  logic [63:0]        req_a0,
  input  logic [63:0]        req_b0,
  input  logic [63:0]        req_a1,
  input  logic [63:0]        req_b1,
  input  logic [TAG_W-1:0]   req_tag0,
  input  logic [TAG_W-1:0]   req_tag1,
  output logic [63:0]        mul_a,
  output logic [63:0]        mul_b,
  input  logic [127:0]       mul_p,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_lane,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic [127:0]       rsp_prod,
  output logic               busy
);

  localparam int unsigned CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               rr_ptr_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q;
  logic               lane_q;
  logic [TAG_W-1:0]   tag_q;
  logic [63:0]        ma_q, mb_q;
  logic [127:0]       prod_q;

  // Arbitration and operand preparation for the lane that would win now
  logic               win;
  logic [1:0]         gnt;
  logic               accept;
  logic               sel_sgn;
  logic [63:0]        sel_a, sel_b;
  logic [63:0]        mag_a, mag_b;
  logic               neg_d;
  logic [127:0]       final_p;

  always_comb begin
    case (req_valid)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = rr_ptr_q;
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    sel_a   = win ? req_a1 : req_a0;
    sel_b   = win ? req_b1 : req_b0;
    sel_sgn = req_sgn[win];
    // Negating 0x8000..0 wraps back to itself, which is the correct
    // unsigned magnitude of -2^63.
    mag_a   = (sel_sgn && sel_a[63]) ? (~sel_a + 64'd1) : sel_a;
    mag_b   = (sel_sgn && sel_b[63]) ? (~sel_b + 64'd1) : sel_b;
    neg_d   = sel_sgn & (sel_a[63] ^ sel_b[63]);
    final_p = neg_q ? (~mul_p + 128'd1) : mul_p;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept)               state_d = S_BUSY;
      S_BUSY: if (cnt_q == CW'(1))      state_d = S_DONE;
      S_DONE: if (rsp_ready)            state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt = 2'b00;
    if (state_q == S_IDLE && req_valid != 2'b00)
      gnt = win ? 2'b10 : 2'b01;
    accept    = (gnt != 2'b00);
    req_ready = gnt;
    rsp_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  // Operand / result datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      lane_q   <= 1'b0;
      tag_q    <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      prod_q   <= '0;
    end else if (accept) begin
      rr_ptr_q <= ~win;
      cnt_q    <= CW'(LAT);
      neg_q    <= neg_d;
      lane_q   <= win;
      tag_q    <= win ? req_tag1 : req_tag0;
      ma_q     <= mag_a;
      mb_q     <= mag_b;
    end else if (state_q == S_BUSY) begin
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1))
        prod_q <= final_p;
    end
  end

  assign mul_a    = ma_q;
  assign mul_b    = mb_q;
  assign rsp_lane = lane_q;
  assign rsp_tag  = tag_q;
  assign rsp_prod = prod_q;

endmodule
